// File: rtl/tft_spi_tx.sv
// Write-only SPI byte transmitter for the TFT panel: mode 0, MSB first, cs framing,
// dc held for the whole byte, busy/done handshake back to the byte source.
module tft_spi_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       done,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs,
  output logic       spi_dc,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GUARD} state_t;

  state_t      state;
  logic [7:0]  shift;
  logic [2:0]  bitcnt;
  logic [15:0] div_cnt;
  logic        div_end;

  assign div_end   = (div_cnt == 16'(CLK_DIV - 1));
  assign fsm_state = state;

  // Handshake: a request is taken only in IDLE; busy rises on the accept edge and
  // falls together with the one-cycle done pulse, so requests while busy are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= 8'h00;
      bitcnt   <= 3'd0;
      div_cnt  <= 16'd0;
      tft_busy <= 1'b0;
      done     <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs   <= 1'b1;
      spi_dc   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= 16'd0;
          if (tft_transmit) begin
            shift    <= tft_data;
            spi_dc   <= tft_dc;
            tft_busy <= 1'b1;
            spi_cs   <= 1'b0;
            spi_mosi <= tft_data[7];
            bitcnt   <= 3'd7;
            state    <= LOW;
          end
        end
        LOW: begin
          if (div_end) begin
            div_cnt <= 16'd0;
            spi_sck <= 1'b1;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        HIGH: begin
          if (div_end) begin
            div_cnt <= 16'd0;
            spi_sck <= 1'b0;
            if (bitcnt != 3'd0) begin
              // shift[7] is the bit on the wire; the next one moves out on the falling edge.
              spi_mosi <= shift[6];
              shift    <= {shift[6:0], 1'b0};
              bitcnt   <= bitcnt - 3'd1;
              state    <= LOW;
            end else begin
              spi_cs <= 1'b1;
              state  <= GUARD;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        GUARD: begin
          if (div_end) begin
            div_cnt  <= 16'd0;
            tft_busy <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Bench for tft_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1) checked each cycle
// against a cycle-offset model, plus an SPI decoder feeding a byte scoreboard.
module tb_tft_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       tx   [2];
  logic       dcin [2];
  logic [7:0] din  [2];
  logic       busy [2];
  logic       done [2];
  logic       sck  [2];
  logic       mosi [2];
  logic       cs   [2];
  logic       dco  [2];
  logic [1:0] st   [2];

  tft_spi_tx #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst[0]), .tft_transmit(tx[0]), .tft_dc(dcin[0]), .tft_data(din[0]),
    .tft_busy(busy[0]), .done(done[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
    .spi_cs(cs[0]), .spi_dc(dco[0]), .fsm_state(st[0])
  );

  tft_spi_tx #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst[1]), .tft_transmit(tx[1]), .tft_dc(dcin[1]), .tft_data(din[1]),
    .tft_busy(busy[1]), .done(done[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
    .spi_cs(cs[1]), .spi_dc(dco[1]), .fsm_state(st[1])
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // ---------------- behavioural model: outputs as a function of cycles since accept
  int         ph    [2];
  logic [7:0] md    [2];
  logic       mdc   [2];
  logic       mhold [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; md[i] = 8'h00; mdc[i] = 1'b0; mhold[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        ph[i] <= 0; mdc[i] <= 1'b0; mhold[i] <= 1'b0;
      end else if ((ph[i] == 0 || ph[i] == 17 * div_of(i) + 1) && tx[i]) begin
        ph[i] <= 1; md[i] <= din[i]; mdc[i] <= dcin[i]; mhold[i] <= din[i][0];
      end else if (ph[i] == 17 * div_of(i) + 1) begin
        ph[i] <= 0;
      end else if (ph[i] != 0) begin
        ph[i] <= ph[i] + 1;
      end
    end
  end

  // {busy, done, sck, mosi, cs, dc}
  function automatic logic [5:0] expv(input int p, input int d, input logic [7:0] data,
                                      input logic dc, input logic hold);
    logic in_frame, b, dn, s, m, c;
    in_frame = (p >= 1) && (p <= 16 * d);
    b  = (p >= 1) && (p <= 17 * d);
    dn = (p == 17 * d + 1);
    c  = !in_frame;
    s  = in_frame && ((((p - 1) / d) % 2) == 1);
    m  = in_frame ? data[7 - ((p - 1) / (2 * d))] : hold;
    return {b, dn, s, m, c, dc};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++)
        chk($sformatf("cycle_outputs_div%0d", div_of(i)),
            {26'd0, busy[i], done[i], sck[i], mosi[i], cs[i], dco[i]},
            {26'd0, expv(ph[i], div_of(i), md[i], mdc[i], mhold[i])});
    end
  end

  // ---------------- SPI decoder and scoreboard
  logic [8:0] exp_q[$];
  logic [8:0] exp_q1[$];
  logic       psck [2];
  logic       pcs  [2];
  logic [7:0] sh   [2];
  logic       fdc  [2];
  int nb[2], frames[2], dones[2], cs_hi_run[2], min_gap[2], busy_run[2], last_busy[2];
  int prev_fall = 0;
  int last_fall = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; frames[i] = 0; dones[i] = 0; cs_hi_run[i] = 0; min_gap[i] = 999;
      busy_run[i] = 0; last_busy[i] = 0; sh[i] = 8'h00; fdc[i] = 1'b0;
      psck[i] = 1'b0; pcs[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) busy_run[i]++;
        else if (busy_run[i] > 0) begin
          last_busy[i] = busy_run[i];
          busy_run[i] = 0;
        end
        if (done[i]) dones[i]++;
        if (rst[i]) begin
          nb[i] = 0;
        end else begin
          if (!psck[i] && sck[i] && !cs[i]) begin
            if (nb[i] == 0) fdc[i] = dco[i];
            sh[i] = {sh[i][6:0], mosi[i]};
            nb[i]++;
          end
          if (pcs[i] && !cs[i]) begin
            if (cs_hi_run[i] < min_gap[i]) min_gap[i] = cs_hi_run[i];
            if (i == 0) begin
              prev_fall = last_fall;
              last_fall = cyc;
            end
          end
          if (!pcs[i] && cs[i] && nb[i] != 0) begin
            frames[i]++;
            chk($sformatf("frame_bits_div%0d", div_of(i)), nb[i], 8);
            if (i == 0) begin
              chk("frame_expected_div2", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) chk("frame_byte_div2", {fdc[i], sh[i]}, exp_q.pop_front());
            end else begin
              chk("frame_expected_div1", exp_q1.size() > 0, 1);
              if (exp_q1.size() > 0) chk("frame_byte_div1", {fdc[i], sh[i]}, exp_q1.pop_front());
            end
            nb[i] = 0;
          end
        end
        cs_hi_run[i] = cs[i] ? cs_hi_run[i] + 1 : 0;
        psck[i] = sck[i];
        pcs[i]  = cs[i];
      end
    end
  end

  // ---------------- driver tasks
  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("wait_idle_timeout", busy[i], 0);
  endtask

  task automatic send(input int i, input logic dc, input logic [7:0] data);
    wait_idle(i);
    tx[i] = 1'b1; dcin[i] = dc; din[i] = data;
    @(posedge clk); #1;
    tx[i] = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, n, d0;
    logic prev;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; tx[i] = 1'b0; dcin[i] = 1'b0; din[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    cmp_en = 1'b1;
    chk("reset_outputs_div2", {busy[0], done[0], sck[0], mosi[0], cs[0], dco[0]}, 6'b000010);
    chk("reset_outputs_div1", {busy[1], done[1], sck[1], mosi[1], cs[1], dco[1]}, 6'b000010);
    chk("reset_state_div2", st[0], 0);
    repeat (3) @(posedge clk);
    #1;

    // 0xA5 command byte, with a second request 3 cycles in that must be dropped
    d0 = dones[0];
    exp_q.push_back(9'h0A5);
    send(0, 1'b0, 8'hA5);
    repeat (2) @(posedge clk);
    #1;
    tx[0] = 1'b1; dcin[0] = 1'b1; din[0] = 8'hFF;
    @(posedge clk); #1;
    tx[0] = 1'b0;
    wait_idle(0);
    settle();
    chk("a5_busy_len", last_busy[0], 34);
    chk("a5_done_pulses", dones[0] - d0, 1);
    chk("a5_frames", frames[0], 1);

    // sequencer-style burst, each byte issued as soon as busy drops
    min_gap[0] = 999;
    exp_q.push_back(9'h0C0);
    exp_q.push_back(9'h117);
    exp_q.push_back(9'h115);
    send(0, 1'b0, 8'hC0);
    send(0, 1'b1, 8'h17);
    send(0, 1'b1, 8'h15);
    wait_idle(0);
    settle();
    chk("burst_frames", frames[0], 4);
    chk("burst_min_gap", min_gap[0], 3);

    // reset after the third sck rise of a 0x3C frame abandons it
    d0 = dones[0];
    send(0, 1'b0, 8'h3C);
    rises = 0; n = 0; prev = sck[0];
    while (rises < 3 && n < 200) begin
      @(posedge clk); #1;
      if (!prev && sck[0]) rises++;
      prev = sck[0];
      n++;
    end
    chk("abort_rises", rises, 3);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("abort_cs", cs[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    exp_q.push_back(9'h081);
    send(0, 1'b0, 8'h81);
    wait_idle(0);
    settle();
    chk("abort_frames", frames[0], 5);
    chk("abort_done_pulses", dones[0] - d0, 1);

    // fastest divider: single 0x01 data byte
    exp_q1.push_back(9'h101);
    send(1, 1'b1, 8'h01);
    wait_idle(1);
    settle();
    chk("div1_busy_len", last_busy[1], 17);
    chk("div1_frames", frames[1], 1);

    // transmit held for 40 cycles: accepts at cycle 0 and 35 only
    min_gap[0] = 999;
    exp_q.push_back(9'h15A);
    exp_q.push_back(9'h15A);
    tx[0] = 1'b1; dcin[0] = 1'b1; din[0] = 8'h5A;
    repeat (40) @(posedge clk);
    #1;
    tx[0] = 1'b0;
    wait_idle(0);
    settle();
    chk("held_frames", frames[0], 7);
    chk("held_accept_spacing", last_fall - prev_fall, 35);
    chk("held_min_gap", min_gap[0], 3);

    chk("queue_drained_div2", exp_q.size(), 0);
    chk("queue_drained_div1", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
